// File: rtl/f_bpred_npc.sv
// rtl/f_bpred_npc.sv - fetch-stage next-PC generator with BTB/BHT branch prediction
module f_bpred_npc #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
    parameter int              IDX_BITS = 6,
    parameter int              TAG_BITS = 8,
    parameter logic [1:0]      CTR_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_stall,
    input  logic             in_Dvalid,
    input  logic [WIDTH-1:0] in_Dpc,
    input  logic [1:0]       in_Dkind,
    input  logic             in_Dtaken,
    input  logic [WIDTH-1:0] in_Dtarget,
    input  logic [WIDTH-1:0] in_Dpred_npc,
    output logic [WIDTH-1:0] out_Fpc,
    output logic             out_Fpred_taken,
    output logic [WIDTH-1:0] out_Fpred_npc,
    output logic             out_redirect,
    output logic [31:0]      out_cti_cnt,
    output logic [31:0]      out_mispred_cnt
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_COND = 2'b01;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [WIDTH-1:0]    target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [1:0]          kind_q   [ENTRIES];

    logic [WIDTH-1:0] fpc_q;
    logic [31:0]      cti_cnt;
    logic [31:0]      mispred_cnt;

    logic [IDX_BITS-1:0] f_idx, d_idx;
    logic [TAG_BITS-1:0] f_tag, d_tag;
    logic                f_hit, d_hit;
    logic                resolve;
    logic [WIDTH-1:0]    actual_npc;
    logic [WIDTH-1:0]    next_fpc;

    assign f_idx = fpc_q[IDX_BITS+1:2];
    assign f_tag = fpc_q[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign d_idx = in_Dpc[IDX_BITS+1:2];
    assign d_tag = in_Dpc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign d_hit = valid_q[d_idx] && (tag_q[d_idx] == d_tag);

    // Unconditional CTIs always predict taken; conditional ones follow the counter MSB
    assign out_Fpred_taken = f_hit && ((kind_q[f_idx] != KIND_COND) || ctr_q[f_idx][1]);
    assign out_Fpred_npc   = out_Fpred_taken ? target_q[f_idx] : fpc_q + WIDTH'(4);
    assign out_Fpc         = fpc_q;

    assign resolve      = in_Dvalid && !in_stall;
    assign actual_npc   = in_Dtaken ? in_Dtarget : in_Dpc + WIDTH'(4);
    assign out_redirect = resolve && (actual_npc != in_Dpred_npc);

    always_comb begin
        next_fpc = out_Fpred_npc;
        if (out_redirect) begin
            next_fpc = actual_npc;
        end else if (in_stall) begin
            next_fpc = fpc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q       <= RESET_PC;
            cti_cnt     <= '0;
            mispred_cnt <= '0;
            valid_q     <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
                kind_q[i]   <= KIND_NONE;
            end
        end else begin
            fpc_q <= next_fpc;
            if (resolve) begin
                case (in_Dkind)
                    KIND_COND: begin
                        if (in_Dtaken) begin
                            if (d_hit) begin
                                ctr_q[d_idx] <= (ctr_q[d_idx] == 2'b11) ? 2'b11 : ctr_q[d_idx] + 2'b01;
                            end else begin
                                valid_q[d_idx] <= 1'b1;
                                tag_q[d_idx]   <= d_tag;
                                ctr_q[d_idx]   <= 2'b10;
                            end
                            target_q[d_idx] <= in_Dtarget;
                            kind_q[d_idx]   <= KIND_COND;
                        end else if (d_hit) begin
                            ctr_q[d_idx] <= (ctr_q[d_idx] == 2'b00) ? 2'b00 : ctr_q[d_idx] - 2'b01;
                        end
                    end
                    KIND_NONE: begin
                        // A non-CTI that hits is an alias left by another PC; drop it
                        if (d_hit) begin
                            valid_q[d_idx] <= 1'b0;
                        end
                    end
                    default: begin
                        valid_q[d_idx]  <= 1'b1;
                        tag_q[d_idx]    <= d_tag;
                        target_q[d_idx] <= in_Dtarget;
                        ctr_q[d_idx]    <= 2'b11;
                        kind_q[d_idx]   <= in_Dkind;
                    end
                endcase
                if ((in_Dkind != KIND_NONE) && (cti_cnt != 32'hFFFF_FFFF)) begin
                    cti_cnt <= cti_cnt + 32'd1;
                end
            end
            if (out_redirect && (mispred_cnt != 32'hFFFF_FFFF)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

    assign out_cti_cnt     = cti_cnt;
    assign out_mispred_cnt = mispred_cnt;
endmodule

// File: tb/tb_f_bpred_npc.sv
// tb/tb_f_bpred_npc.sv - self-checking bench for f_bpred_npc
module tb_f_bpred_npc;
    logic        clk = 1'b0;
    logic        reset, in_stall, in_Dvalid, in_Dtaken;
    logic [31:0] in_Dpc, in_Dtarget, in_Dpred_npc;
    logic [1:0]  in_Dkind;
    logic [31:0] out_Fpc, out_Fpred_npc, out_cti_cnt, out_mispred_cnt;
    logic        out_Fpred_taken, out_redirect;

    int checks = 0;
    int errors = 0;

    f_bpred_npc dut (
        .clk(clk), .reset(reset), .in_stall(in_stall), .in_Dvalid(in_Dvalid),
        .in_Dpc(in_Dpc), .in_Dkind(in_Dkind), .in_Dtaken(in_Dtaken),
        .in_Dtarget(in_Dtarget), .in_Dpred_npc(in_Dpred_npc),
        .out_Fpc(out_Fpc), .out_Fpred_taken(out_Fpred_taken), .out_Fpred_npc(out_Fpred_npc),
        .out_redirect(out_redirect), .out_cti_cnt(out_cti_cnt), .out_mispred_cnt(out_mispred_cnt)
    );

    always #5 clk = ~clk;

    // Reference predictor: one record per table slot, indexed by PC word bits
    bit          m_valid [64];
    logic [7:0]  m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    logic [1:0]  m_kind  [64];
    logic [1:0]  prog_kind [64];
    logic [31:0] prog_tgt  [64];

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[pc[7:2]] && (m_tag[pc[7:2]] == pc[15:8]);
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_kind[pc[7:2]] != 2'b01 || m_ctr[pc[7:2]] >= 2);
    endfunction

    function automatic logic [31:0] m_npc(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[pc[7:2]] : pc + 32'd4;
    endfunction

    task automatic m_update(input logic [31:0] pc, input logic [1:0] kind,
                            input bit taken, input logic [31:0] target);
        int i = int'(pc[7:2]);
        bit h = m_hit(pc);
        if (kind == 2'b01 && taken && h) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = target;
        end else if (kind == 2'b01 && taken) begin
            m_valid[i] = 1; m_tag[i] = pc[15:8]; m_tgt[i] = target; m_ctr[i] = 2; m_kind[i] = 2'b01;
        end else if (kind == 2'b01 && h) begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else if (kind[1]) begin
            m_valid[i] = 1; m_tag[i] = pc[15:8]; m_tgt[i] = target; m_ctr[i] = 3; m_kind[i] = kind;
        end else if (kind == 2'b00 && h) begin
            m_valid[i] = 0;
        end
    endtask

    task automatic set_d(input bit stall, input bit v, input logic [31:0] pc, input logic [1:0] kind,
                         input bit tk, input logic [31:0] tgt, input logic [31:0] pred);
        in_stall = stall; in_Dvalid = v; in_Dpc = pc; in_Dkind = kind;
        in_Dtaken = tk; in_Dtarget = tgt; in_Dpred_npc = pred;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_d(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        if (out_Fpc !== 32'h3000) begin errors++; $display("FAIL reset_fpc got %h want 3000", out_Fpc); end
        checks++;
        if (out_Fpred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b want 0", out_Fpred_taken); end
        checks++;
        if (out_Fpred_npc !== 32'h3004) begin errors++; $display("FAIL reset_npc got %h want 3004", out_Fpred_npc); end
        checks++;
        if (out_redirect !== 1'b0 || out_cti_cnt !== 0 || out_mispred_cnt !== 0) begin
            errors++; $display("FAIL reset_counts got red=%b cti=%0d mis=%0d want 0/0/0", out_redirect, out_cti_cnt, out_mispred_cnt);
        end
        checks++;
    endtask

    task automatic test_cold_beq();
        do_reset();
        set_d(0, 1, 32'h3010, 2'b01, 1, 32'h3000, 32'h3014);
        #1;
        if (out_redirect !== 1'b1) begin errors++; $display("FAIL beq_cold_redirect got %b want 1", out_redirect); end
        checks++;
        next_cycle();
        set_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        if (out_Fpc !== 32'h3000 || out_cti_cnt !== 1 || out_mispred_cnt !== 1) begin
            errors++; $display("FAIL beq_cold_after got pc=%h cti=%0d mis=%0d want 3000/1/1", out_Fpc, out_cti_cnt, out_mispred_cnt);
        end
        checks++;
        repeat (4) next_cycle();
        #1;
        if (out_Fpc !== 32'h3010 || out_Fpred_taken !== 1'b1 || out_Fpred_npc !== 32'h3000) begin
            errors++; $display("FAIL beq_trained got pc=%h tk=%b npc=%h want 3010/1/3000", out_Fpc, out_Fpred_taken, out_Fpred_npc);
        end
        checks++;
        set_d(0, 1, 32'h3010, 2'b01, 1, 32'h3000, 32'h3000);
        #1;
        if (out_redirect !== 1'b0) begin errors++; $display("FAIL beq_correct_redirect got %b want 0", out_redirect); end
        checks++;
        next_cycle();
        set_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        if (out_Fpc !== 32'h3000 || out_cti_cnt !== 2 || out_mispred_cnt !== 1) begin
            errors++; $display("FAIL beq_follow got pc=%h cti=%0d mis=%0d want 3000/2/1", out_Fpc, out_cti_cnt, out_mispred_cnt);
        end
        checks++;
    endtask

    // Runs right after test_cold_beq: entry for 0x3010 is at ctr=11
    task automatic test_not_taken();
        set_d(0, 1, 32'h3010, 2'b01, 0, 32'h3000, 32'h3000);
        #1;
        if (out_redirect !== 1'b1) begin errors++; $display("FAIL nt_redirect got %b want 1", out_redirect); end
        checks++;
        next_cycle();
        if (out_Fpc !== 32'h3014 || out_mispred_cnt !== 2) begin
            errors++; $display("FAIL nt_after got pc=%h mis=%0d want 3014/2", out_Fpc, out_mispred_cnt);
        end
        checks++;
        set_d(0, 1, 32'h3040, 2'b10, 1, 32'h3010, 32'h3044);
        next_cycle();
        set_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        if (out_Fpc !== 32'h3010 || out_Fpred_taken !== 1'b1 || out_Fpred_npc !== 32'h3000) begin
            errors++; $display("FAIL nt_still_taken got pc=%h tk=%b npc=%h want 3010/1/3000", out_Fpc, out_Fpred_taken, out_Fpred_npc);
        end
        checks++;
    endtask

    task automatic test_stall();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_d(1, 1, 32'h3010, 2'b01, 1, 32'h3080, 32'h3014);
            #1;
            if (out_redirect !== 1'b0 || out_Fpc !== 32'h3000) begin
                errors++; $display("FAIL stall_hold got red=%b pc=%h want 0/3000", out_redirect, out_Fpc);
            end
            checks++;
            next_cycle();
        end
        if (out_cti_cnt !== 0 || out_mispred_cnt !== 0 || out_Fpc !== 32'h3000) begin
            errors++; $display("FAIL stall_counts got cti=%0d mis=%0d pc=%h want 0/0/3000", out_cti_cnt, out_mispred_cnt, out_Fpc);
        end
        checks++;
        set_d(0, 1, 32'h3010, 2'b01, 1, 32'h3080, 32'h3014);
        #1;
        if (out_redirect !== 1'b1) begin errors++; $display("FAIL stall_release got %b want 1", out_redirect); end
        checks++;
        next_cycle();
        set_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        if (out_Fpc !== 32'h3080 || out_mispred_cnt !== 1 || out_cti_cnt !== 1) begin
            errors++; $display("FAIL stall_after got pc=%h mis=%0d cti=%0d want 3080/1/1", out_Fpc, out_mispred_cnt, out_cti_cnt);
        end
        checks++;
    endtask

    task automatic test_alias();
        do_reset();
        set_d(0, 1, 32'h3010, 2'b10, 1, 32'h3080, 32'h3014);
        next_cycle();
        set_d(0, 1, 32'h3010, 2'b00, 0, 32'h0, 32'h3080);
        #1;
        if (out_redirect !== 1'b1) begin errors++; $display("FAIL alias_redirect got %b want 1", out_redirect); end
        checks++;
        next_cycle();
        if (out_Fpc !== 32'h3014 || out_cti_cnt !== 1 || out_mispred_cnt !== 2) begin
            errors++; $display("FAIL alias_after got pc=%h cti=%0d mis=%0d want 3014/1/2", out_Fpc, out_cti_cnt, out_mispred_cnt);
        end
        checks++;
        set_d(0, 1, 32'h3040, 2'b10, 1, 32'h3010, 32'h3044);
        next_cycle();
        set_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        if (out_Fpc !== 32'h3010 || out_Fpred_taken !== 1'b0 || out_Fpred_npc !== 32'h3014) begin
            errors++; $display("FAIL alias_invalidated got pc=%h tk=%b npc=%h want 3010/0/3014", out_Fpc, out_Fpred_taken, out_Fpred_npc);
        end
        checks++;
    endtask

    task automatic test_jump_saturate();
        do_reset();
        set_d(0, 1, 32'h3020, 2'b10, 1, 32'h3100, 32'h3024);
        #1;
        if (out_redirect !== 1'b1) begin errors++; $display("FAIL jump_cold got %b want 1", out_redirect); end
        checks++;
        next_cycle();
        if (out_Fpc !== 32'h3100) begin errors++; $display("FAIL jump_target got %h want 3100", out_Fpc); end
        checks++;
        set_d(0, 1, 32'h3040, 2'b10, 1, 32'h3020, 32'h3044);
        next_cycle();
        set_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        if (out_Fpc !== 32'h3020 || out_Fpred_taken !== 1'b1 || out_Fpred_npc !== 32'h3100) begin
            errors++; $display("FAIL jump_refetch got pc=%h tk=%b npc=%h want 3020/1/3100", out_Fpc, out_Fpred_taken, out_Fpred_npc);
        end
        checks++;
        force dut.mispred_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.mispred_cnt;
        set_d(0, 1, 32'h3020, 2'b10, 1, 32'h3100, 32'h3024);
        next_cycle();
        set_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        if (out_mispred_cnt !== 32'hFFFF_FFFF || out_cti_cnt !== 3) begin
            errors++; $display("FAIL mispred_saturate got mis=%h cti=%0d want ffffffff/3", out_mispred_cnt, out_cti_cnt);
        end
        checks++;
    endtask

    task automatic test_random();
        bit          d_valid, d_taken, stall, res, e_red;
        logic [31:0] d_pc, d_tgt, d_pred, actual, e_npc, nxt, m_pc;
        logic [1:0]  d_kind;
        bit          e_tk;
        longint      m_cti, m_mis;
        for (int i = 0; i < 64; i++) begin
            prog_kind[i] = (i == 63) ? 2'b10 : 2'($urandom_range(0, 3));
            prog_tgt[i]  = 32'h3000 + 32'($urandom_range(0, 63)) * 4;
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1; m_kind[i] = 0;
        end
        do_reset();
        m_pc = 32'h3000; m_cti = 0; m_mis = 0;
        d_valid = 0; d_pc = 0; d_kind = 0; d_taken = 0; d_tgt = 0; d_pred = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall = ($urandom_range(0, 5) == 0);
            set_d(stall, d_valid, d_pc, d_kind, d_taken, d_tgt, d_pred);
            #1;
            e_tk   = m_taken(m_pc);
            e_npc  = m_npc(m_pc);
            res    = d_valid && !stall;
            actual = d_taken ? d_tgt : d_pc + 32'd4;
            e_red  = res && (actual != d_pred);
            if (out_Fpc !== m_pc || out_Fpred_taken !== e_tk || out_Fpred_npc !== e_npc) begin
                errors++; $display("FAIL rand_predict cyc=%0d got pc=%h tk=%b npc=%h want %h/%b/%h",
                                   cyc, out_Fpc, out_Fpred_taken, out_Fpred_npc, m_pc, e_tk, e_npc);
            end
            checks++;
            if (out_redirect !== e_red) begin
                errors++; $display("FAIL rand_redirect cyc=%0d got %b want %b", cyc, out_redirect, e_red);
            end
            checks++;
            if (out_cti_cnt !== 32'(m_cti) || out_mispred_cnt !== 32'(m_mis)) begin
                errors++; $display("FAIL rand_counts cyc=%0d got cti=%0d mis=%0d want %0d/%0d",
                                   cyc, out_cti_cnt, out_mispred_cnt, m_cti, m_mis);
            end
            checks++;
            if (res) begin
                m_update(d_pc, d_kind, d_taken, d_tgt);
                if (d_kind != 2'b00) m_cti++;
            end
            if (e_red) m_mis++;
            nxt = e_red ? actual : (stall ? m_pc : e_npc);
            if (e_red) begin
                d_valid = 0;
            end else if (!stall) begin
                d_valid = 1;
                d_pc    = m_pc;
                d_kind  = prog_kind[m_pc[7:2]];
                d_pred  = e_npc;
                case (d_kind)
                    2'b00: begin d_taken = 0; d_tgt = 0; end
                    2'b01: begin
                        d_taken = m_pc[2] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                        d_tgt   = prog_tgt[m_pc[7:2]];
                    end
                    2'b10: begin d_taken = 1; d_tgt = prog_tgt[m_pc[7:2]]; end
                    default: begin d_taken = 1; d_tgt = 32'h3000 + 32'($urandom_range(0, 63)) * 4; end
                endcase
            end
            m_pc = nxt;
            next_cycle();
        end
    endtask

    task automatic test_reset_midrun();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        if (out_Fpc !== 32'h3000 || out_Fpred_taken !== 1'b0 || out_Fpred_npc !== 32'h3004) begin
            errors++; $display("FAIL midrun_reset_pred got pc=%h tk=%b npc=%h want 3000/0/3004", out_Fpc, out_Fpred_taken, out_Fpred_npc);
        end
        checks++;
        if (out_cti_cnt !== 0 || out_mispred_cnt !== 0) begin
            errors++; $display("FAIL midrun_reset_counts got cti=%0d mis=%0d want 0/0", out_cti_cnt, out_mispred_cnt);
        end
        checks++;
        @(negedge clk);
        set_d(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        next_cycle();
        if (out_Fpc !== 32'h3004) begin errors++; $display("FAIL midrun_restart got %h want 3004", out_Fpc); end
        checks++;
    endtask

    initial begin
        reset = 1'b1;
        set_d(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_cold_beq();
        test_not_taken();
        test_stall();
        test_alias();
        test_jump_saturate();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
